// File: rtl/program_counter.sv
// Fetch-stage program counter.
// Holds the address of the instruction currently being fetched. Each cycle
// the PC either holds (stall), loads a redirect target from the ALU
// (taken jump/branch), or advances sequentially by PC_INC. pc_out is taken
// straight from the register, so no input has a combinational path to it.
module program_counter #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] alu_out,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_seq;

    // Sequential successor; plain 32-bit add, so it wraps modulo 2^32 silently.
    assign pc_seq = pc_q + PC_INC;

    // Next-PC selection: stall beats redirect, redirect beats sequential.
    // The redirect target is loaded verbatim with no alignment masking.
    always_comb begin
        pc_d = pc_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (pc_sel) begin
            pc_d = alu_out;
        end else begin
            pc_d = pc_seq;
        end
    end

    // PC register; reset acts immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized traffic checked against a behavioural next-PC model.
module tb_program_counter;

    localparam logic [31:0] RST_PC = 32'h0000_2000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_sel;
    logic [31:0] alu_out;
    logic [31:0] pc_out;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_pc;

    program_counter dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .pc_sel  (pc_sel),
        .alu_out (alu_out),
        .pc_out  (pc_out)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule for one clock edge with reset low.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic st,
                                               input logic sel, input logic [31:0] tgt);
        if (st) return cur;
        if (sel) return tgt;
        return cur + 32'd4;
    endfunction

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; pc_sel = 1'b1; alu_out = 32'hDEAD_BEEC;
        #1;
        n_cmp++;
        if (pc_out !== RST_PC) begin
            n_err++;
            $display("FAIL reset_initial: got %h want %h", pc_out, RST_PC);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc_out !== RST_PC) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, pc_out, RST_PC);
            end
            $display("reset hold %0d: pc_out=%h", i, pc_out);
        end
        // Leave reset, take one sequential step, then reassert between edges.
        reset = 1'b0; pc_sel = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_2004) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", pc_out, 32'h0000_2004);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc_out !== RST_PC) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", pc_out, RST_PC);
        end
        $display("async reset: pc_out=%h", pc_out);
        tick();
        reset = 1'b0;
        exp_pc = RST_PC;
    endtask

    task automatic test_sequential();
        stall = 1'b0; pc_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = RST_PC + 32'd4 * (i + 1);
            n_cmp++;
            if (pc_out !== exp_pc) begin
                n_err++;
                $display("FAIL sequential[%0d]: got %h want %h", i, pc_out, exp_pc);
            end
            $display("sequential %0d: pc_out=%h", i, pc_out);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b0; pc_sel = 1'b1; alu_out = 32'h0000_1234;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL redirect_load: got %h want %h", pc_out, 32'h0000_1234);
        end
        pc_sel = 1'b0; alu_out = 32'h5555_5555;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_1238) begin
            n_err++;
            $display("FAIL redirect_next: got %h want %h", pc_out, 32'h0000_1238);
        end
        $display("redirect: pc_out=%h", pc_out);
    endtask

    task automatic test_stall_priority();
        stall = 1'b1; pc_sel = 1'b1; alu_out = 32'h0000_4000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc_out !== 32'h0000_1238) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, pc_out, 32'h0000_1238);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_4000) begin
            n_err++;
            $display("FAIL stall_release: got %h want %h", pc_out, 32'h0000_4000);
        end
        $display("stall priority: pc_out=%h", pc_out);
    endtask

    task automatic test_wrap();
        stall = 1'b0; pc_sel = 1'b1; alu_out = 32'hFFFF_FFFC;
        tick();
        n_cmp++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_load: got %h want %h", pc_out, 32'hFFFF_FFFC);
        end
        pc_sel = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_zero: got %h want %h", pc_out, 32'h0000_0000);
        end
        $display("wrap: pc_out=%h", pc_out);
    endtask

    task automatic test_reset_mid();
        stall = 1'b0; pc_sel = 1'b1; alu_out = 32'h0000_4000;
        tick();
        stall = 1'b1;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_4000) begin
            n_err++;
            $display("FAIL mid_before: got %h want %h", pc_out, 32'h0000_4000);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc_out !== RST_PC) begin
            n_err++;
            $display("FAIL mid_reset: got %h want %h", pc_out, RST_PC);
        end
        tick();
        reset = 1'b0; stall = 1'b0; pc_sel = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0000_2004) begin
            n_err++;
            $display("FAIL mid_release: got %h want %h", pc_out, 32'h0000_2004);
        end
        $display("reset mid-op: pc_out=%h", pc_out);
        exp_pc = pc_out === 32'h0000_2004 ? pc_out : 32'h0000_2004;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 300; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            pc_sel = ($urandom_range(0, 2) == 0);
            tgt    = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
            alu_out = tgt;
            if ($urandom_range(0, 24) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                exp_pc = RST_PC;
                n_cmp++;
                if (pc_out !== exp_pc) begin
                    n_err++;
                    $display("FAIL rand_async[%0d]: got %h want %h", i, pc_out, exp_pc);
                end
                tick();
                n_cmp++;
                if (pc_out !== exp_pc) begin
                    n_err++;
                    $display("FAIL rand_reset_hold[%0d]: got %h want %h", i, pc_out, exp_pc);
                end
                reset = 1'b0;
            end else begin
                exp_pc = model_next(exp_pc, stall, pc_sel, tgt);
                tick();
                n_cmp++;
                if (pc_out !== exp_pc) begin
                    n_err++;
                    $display("FAIL rand_step[%0d]: got %h want %h", i, pc_out, exp_pc);
                end
            end
            $display("rand %0d: stall=%0b sel=%0b alu=%h pc_out=%h", i, stall, pc_sel, tgt, pc_out);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_pc = RST_PC;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_priority();
        test_wrap();
        test_reset_mid();
        exp_pc = 32'h0000_2004;
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
